// File: rtl/gain_offset_clamp_mc_if.sv
// Sample/config/status bundle for the multi-channel gain/offset/clamp stage.
// master = sample source and config writer, slave = the datapath.
interface gain_offset_clamp_mc_if #(
  parameter int NCH           = 2,
  parameter int IN_WIDTH      = 8,
  parameter int GAIN_WIDTH    = 16,
  parameter int OFFSET_WIDTH  = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int SAT_CNT_WIDTH = 16
);
  logic                           in_valid;
  logic [NCH*IN_WIDTH-1:0]        in;
  logic                           cfg_load;
  logic [NCH*GAIN_WIDTH-1:0]      cfg_gain;
  logic [NCH*OFFSET_WIDTH-1:0]    cfg_offset;
  logic                           sat_clear;
  logic                           out_valid;
  logic [NCH*OUT_WIDTH-1:0]       out;
  logic [NCH-1:0]                 out_sat;
  logic [SAT_CNT_WIDTH-1:0]       sat_count;

  modport master (
    output in_valid, in, cfg_load, cfg_gain, cfg_offset, sat_clear,
    input  out_valid, out, out_sat, sat_count
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_gain, cfg_offset, sat_clear,
    output out_valid, out, out_sat, sat_count
  );
endinterface

// File: rtl/gain_offset_clamp_mc.sv
// Multi-channel signed gain, rounding, offset and saturation with a fixed
// four-stage pipeline, per-sample coherent config and a sticky sat counter.
module gain_offset_clamp_mc #(
  parameter int NCH           = 2,
  parameter int IN_WIDTH      = 8,
  parameter int GAIN_WIDTH    = 16,
  parameter int GAIN_RADIX    = 8,
  parameter int OFFSET_WIDTH  = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int ROUND         = 1,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  gain_offset_clamp_mc_if.slave bus
);
  localparam int PW = IN_WIDTH + GAIN_WIDTH;
  localparam int SW = PW - GAIN_RADIX + 1;

  localparam logic signed [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << GAIN_RADIX;
  localparam logic signed [PW:0] RND =
    (ROUND != 0 && GAIN_RADIX > 0) ? ((PW+1)'(1) << (GAIN_RADIX-1)) : '0;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [GAIN_WIDTH-1:0]   act_gain [NCH];
  logic signed [OFFSET_WIDTH-1:0] act_off  [NCH];

  logic                           s1_valid, s2_valid, s3_valid;
  logic signed [IN_WIDTH-1:0]     s1_in    [NCH];
  logic signed [GAIN_WIDTH-1:0]   s1_gain  [NCH];
  logic signed [OFFSET_WIDTH-1:0] s1_off   [NCH];
  logic signed [PW-1:0]           s2_prod  [NCH];
  logic signed [OFFSET_WIDTH-1:0] s2_off   [NCH];
  logic signed [SW-1:0]           s3_val   [NCH];

  logic signed [PW:0]             rnd_sum    [NCH];
  logic signed [SW-1:0]           s3_next    [NCH];
  logic [OUT_WIDTH-1:0]           clamp_next [NCH];
  logic [NCH-1:0]                 sat_next;

  logic                           out_valid_q;
  logic [NCH*OUT_WIDTH-1:0]       out_q;
  logic [NCH-1:0]                 out_sat_q;
  logic [SAT_CNT_WIDTH-1:0]       sat_count_q;

  always_comb begin
    sat_next = '0;
    for (int c = 0; c < NCH; c++) begin
      rnd_sum[c] = (PW+1)'(s2_prod[c]) + RND;
      s3_next[c] = SW'(rnd_sum[c] >>> GAIN_RADIX) + SW'(s2_off[c]);
      clamp_next[c] = s3_val[c][OUT_WIDTH-1:0];
      if (s3_val[c] > MAXV) begin
        clamp_next[c] = MAXV[OUT_WIDTH-1:0];
        sat_next[c]   = 1'b1;
      end else if (s3_val[c] < MINV) begin
        clamp_next[c] = MINV[OUT_WIDTH-1:0];
        sat_next[c]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sat_q   <= '0;
      sat_count_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        act_gain[c] <= UNITY;
        act_off[c]  <= '0;
      end
    end else begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      s3_valid    <= s2_valid;
      out_valid_q <= s3_valid;
      for (int c = 0; c < NCH; c++) begin
        // A sample coincident with cfg_load takes the new values on every channel.
        if (bus.cfg_load) begin
          act_gain[c] <= bus.cfg_gain[c*GAIN_WIDTH +: GAIN_WIDTH];
          act_off[c]  <= bus.cfg_offset[c*OFFSET_WIDTH +: OFFSET_WIDTH];
          s1_gain[c]  <= bus.cfg_gain[c*GAIN_WIDTH +: GAIN_WIDTH];
          s1_off[c]   <= bus.cfg_offset[c*OFFSET_WIDTH +: OFFSET_WIDTH];
        end else begin
          s1_gain[c]  <= act_gain[c];
          s1_off[c]   <= act_off[c];
        end
        s1_in[c]   <= bus.in[c*IN_WIDTH +: IN_WIDTH];
        s2_prod[c] <= PW'(s1_in[c]) * PW'(s1_gain[c]);
        s2_off[c]  <= s1_off[c];
        s3_val[c]  <= s3_next[c];
        if (s3_valid) out_q[c*OUT_WIDTH +: OUT_WIDTH] <= clamp_next[c];
      end
      if (s3_valid) out_sat_q <= sat_next;
      if (bus.sat_clear)
        sat_count_q <= '0;
      else if (out_valid_q && (|out_sat_q) && (sat_count_q != '1))
        sat_count_q <= sat_count_q + SAT_CNT_WIDTH'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.sat_count = sat_count_q;
endmodule

// File: tb/tb_gain_offset_clamp_mc.sv
// Directed bench: rounding, truncating and 2-bit-counter instances share stimulus.
module tb_gain_offset_clamp_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_bus;
  logic        cfg_load;
  logic [31:0] cfg_gain;
  logic [15:0] cfg_offset;
  logic        sat_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gain_offset_clamp_mc_if bif0 ();
  gain_offset_clamp_mc_if bif1 ();
  gain_offset_clamp_mc_if #(.SAT_CNT_WIDTH(2)) bif2 ();

  assign bif0.in_valid = in_valid;  assign bif1.in_valid = in_valid;  assign bif2.in_valid = in_valid;
  assign bif0.in = in_bus;          assign bif1.in = in_bus;          assign bif2.in = in_bus;
  assign bif0.cfg_load = cfg_load;  assign bif1.cfg_load = cfg_load;  assign bif2.cfg_load = cfg_load;
  assign bif0.cfg_gain = cfg_gain;  assign bif1.cfg_gain = cfg_gain;  assign bif2.cfg_gain = cfg_gain;
  assign bif0.cfg_offset = cfg_offset; assign bif1.cfg_offset = cfg_offset; assign bif2.cfg_offset = cfg_offset;
  assign bif0.sat_clear = sat_clear; assign bif1.sat_clear = sat_clear; assign bif2.sat_clear = sat_clear;

  gain_offset_clamp_mc u_rnd (.clk(clk), .rst(rst), .bus(bif0));
  gain_offset_clamp_mc #(.ROUND(0)) u_trn (.clk(clk), .rst(rst), .bus(bif1));
  gain_offset_clamp_mc #(.SAT_CNT_WIDTH(2)) u_sc2 (.clk(clk), .rst(rst), .bus(bif2));

  typedef struct {
    logic [15:0] g0, g1;
    logic [7:0]  o0, o1, i0, i1;
    logic [7:0]  r0, r1;   // expected with rounding
    logic [7:0]  t0, t1;   // expected with truncation
    logic [1:0]  sat;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; cfg_load = 1'b0; sat_clear = 1'b0;
  endtask

  initial begin
    int nout;
    logic [7:0] e;

    vecs[0] = '{16'd256,  16'd256,  8'd0,    8'd0, 8'd100,  -8'sd100, 8'd100, -8'sd100, 8'd100,  -8'sd100, 2'b00};
    vecs[1] = '{16'd384,  16'd384,  8'd0,    8'd0, 8'd3,    -8'sd3,   8'd5,   -8'sd4,   8'd4,    -8'sd5,   2'b00};
    vecs[2] = '{16'd1024, 16'd1024, 8'd0,    8'd0, 8'd100,  -8'sd100, 8'd127, -8'sd128, 8'd127,  -8'sd128, 2'b11};
    vecs[3] = '{16'd256,  16'd256,  -8'sd128, 8'd0, -8'sd1, 8'd127,   -8'sd128, 8'd127, -8'sd128, 8'd127,  2'b01};
    vecs[4] = '{16'd256,  16'd256,  -8'sd127, 8'd1, -8'sd1, 8'd126,   -8'sd128, 8'd127, -8'sd128, 8'd127,  2'b00};
    vecs[5] = '{-16'sd256, -16'sd256, 8'd0,  8'd0, -8'sd128, 8'd127,  8'd127, -8'sd127, 8'd127,  -8'sd127, 2'b01};
    vecs[6] = '{16'd128,  16'd128,  8'd10, -8'sd10, 8'd5,   -8'sd5,   8'd13,  -8'sd12,  8'd12,   -8'sd13,  2'b00};

    idle(); in_bus = '0; cfg_gain = '0; cfg_offset = '0;
    rst = 1'b1; step(); step(); rst = 1'b0;

    chk("reset out_valid", bif0.out_valid, 0);
    chk("reset out", bif0.out, 0);
    chk("reset out_sat", bif0.out_sat, 0);
    chk("reset sat_count", bif0.sat_count, 0);

    // Unity after reset with latency and hold checks.
    in_valid = 1'b1; in_bus = {-8'sd100, 8'sd100};
    step(); idle();
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("unity no early valid T+%0d", k), bif0.out_valid, 0);
      if (k < 3) step();
    end
    step();
    chk("unity out_valid T+4", bif0.out_valid, 1);
    chk("unity out", bif0.out, {-8'sd100, 8'sd100});
    chk("unity out_sat", bif0.out_sat, 2'b00);
    step();
    chk("unity valid pulse", bif0.out_valid, 0);
    chk("unity out held", bif0.out, {-8'sd100, 8'sd100});

    for (int v = 0; v < 7; v++) begin
      cfg_load = 1'b1; in_valid = 1'b1;
      cfg_gain = {vecs[v].g1, vecs[v].g0};
      cfg_offset = {vecs[v].o1, vecs[v].o0};
      in_bus = {vecs[v].i1, vecs[v].i0};
      step(); idle();
      step(); step(); step();
      chk($sformatf("vec%0d valid", v), bif0.out_valid, 1);
      chk($sformatf("vec%0d out rnd", v), bif0.out, {vecs[v].r1, vecs[v].r0});
      chk($sformatf("vec%0d out trn", v), bif1.out, {vecs[v].t1, vecs[v].t0});
      chk($sformatf("vec%0d sat rnd", v), bif0.out_sat, vecs[v].sat);
      chk($sformatf("vec%0d sat trn", v), bif1.out_sat, vecs[v].sat);
    end
    step(); step();
    chk("sat_count after table", bif0.sat_count, 3);

    // Coherent config switch in the middle of a continuous stream.
    cfg_load = 1'b1; cfg_gain = {16'd256, 16'd256}; cfg_offset = '0;
    step(); idle();
    nout = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; in_bus = {8'd10, 8'd10};
        cfg_load = (cyc == 4);
        cfg_gain = {16'd512, 16'd512};
      end else idle();
      step();
      if (bif0.out_valid) begin
        e = (nout < 4) ? 8'd10 : 8'd20;
        chk($sformatf("coh sample %0d", nout), bif0.out, {e, e});
        nout++;
      end
    end
    idle();
    chk("coh output count", nout, 8);

    sat_clear = 1'b1; step(); sat_clear = 1'b0;
    chk("sat_clear alone", bif0.sat_count, 0);

    // Five saturating samples back to back.
    cfg_load = 1'b1; cfg_gain = {16'd1024, 16'd1024}; cfg_offset = '0;
    in_valid = 1'b1; in_bus = {8'd100, 8'd100};
    step(); cfg_load = 1'b0;
    for (int k = 1; k < 5; k++) step();
    idle();
    for (int k = 0; k < 6; k++) step();
    chk("sat_count 5 sats", bif0.sat_count, 5);
    chk("sat_count 2-bit holds", bif2.sat_count, 3);

    // sat_clear coincident with a saturating output.
    in_valid = 1'b1; in_bus = {8'd100, 8'd100};
    step(); idle(); step(); step(); step();
    chk("coincident out_valid", bif0.out_valid, 1);
    chk("coincident out_sat", bif0.out_sat, 2'b11);
    sat_clear = 1'b1; step(); sat_clear = 1'b0;
    chk("clear wins rnd", bif0.sat_count, 0);
    chk("clear wins sc2", bif2.sat_count, 0);

    // Reset with three saturating samples in flight.
    sat_clear = 1'b1; step(); sat_clear = 1'b0;
    cfg_load = 1'b1; cfg_gain = {16'd512, 16'd512}; in_valid = 1'b1; in_bus = {8'd100, 8'd100};
    step(); cfg_load = 1'b0; step(); step();
    in_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    chk("mid reset out_valid", bif0.out_valid, 0);
    chk("mid reset out", bif0.out, 0);
    nout = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bif0.out_valid) nout++;
    end
    chk("no flushed outputs", nout, 0);
    chk("mid reset sat_count", bif0.sat_count, 0);

    in_valid = 1'b1; in_bus = {8'd50, 8'd50};
    step(); idle(); step(); step(); step();
    chk("post reset valid", bif0.out_valid, 1);
    chk("post reset unity", bif0.out, {8'd50, 8'd50});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
